operand_loader: RTL
===================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter WIDTH, default 8: width of each operand word and of outputs a/b; it SHALL equal the WIDTH of the downstream bitwise AND stage.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 clr  input  1  synchronous abort: discards any partial or held pair.
REQ-005 din  input  WIDTH  operand word offered by the upstream source.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  loader accepts din this cycle.
REQ-008 a  output  WIDTH  first operand, registered; feeds AND-stage input a.
REQ-009 b  output  WIDTH  second operand, registered; feeds AND-stage input b.
REQ-010 out_valid  output  1  a and b form a complete pair.
REQ-011 out_ready  input  1  consumer takes the pair this cycle.
REQ-012 state  output  2  current FSM state, for LED display.
REQ-013 pair_cnt  output  8  count of pairs consumed, modulo 256.

Function
REQ-014 FSM states SHALL be LOAD_A=2'd0, LOAD_B=2'd1 and HOLD=2'd2; 2'd3 is illegal and SHALL go to LOAD_A on the next edge.
REQ-015 din_ready SHALL be 1 in LOAD_A and LOAD_B and 0 in HOLD, decoded from state only, with no combinational path from din_valid or out_ready.
REQ-016 A word is accepted when din_valid & din_ready at a rising edge.
REQ-017 Acceptance in LOAD_A SHALL load a<=din and move to LOAD_B; b is unchanged.
REQ-018 Acceptance in LOAD_B SHALL load b<=din and move to HOLD; out_valid SHALL be 1 in the cycle after acceptance (1-cycle latency).
REQ-019 out_valid SHALL equal (state==HOLD); a and b SHALL stay stable while out_valid=1.
REQ-020 In HOLD, out_ready=1 SHALL move the FSM to LOAD_A and increment pair_cnt by 1, wrapping 255->0.
REQ-021 In HOLD, out_ready=0 SHALL keep the FSM in HOLD indefinitely; din is ignored.
REQ-022 out_ready outside HOLD SHALL have no effect.
REQ-023 din_valid=0 in LOAD_A or LOAD_B SHALL hold state, a and b unchanged.
REQ-024 clr=1 SHALL move the FSM to LOAD_A on the next edge.
REQ-025 clr SHALL take priority over a simultaneous din acceptance or out_ready handshake: no load occurs and pair_cnt does not increment.
REQ-026 clr SHALL leave a, b and pair_cnt at their current values.
REQ-027 After a clr from LOAD_B, the next accepted word SHALL be written to a.

Reset
REQ-028 While rst=1, state=LOAD_A, a=0, b=0 and pair_cnt=0, asynchronously.
REQ-029 While rst=1, din_ready=1 and out_valid=0.
REQ-030 A reset asserted mid-pair or in HOLD SHALL discard the pair without incrementing pair_cnt.
REQ-031 After rst deasserts, the first word accepted SHALL load a.

Structure
REQ-032 The state encodings LOAD_A, LOAD_B and HOLD SHALL be localparams in a shared include file (operand_defs.vh), together with the default WIDTH.
REQ-033 One sub-module, operand_reg, SHALL be used: a WIDTH-bit register with async active-high reset and load enable, instantiated twice (for a and for b).
REQ-034 The FSM and pair_cnt SHALL reside in operand_loader.
REQ-035 The implementation SHALL contain no latches, and every output SHALL be driven from registers or a pure state decode.

Verification
REQ-036 Basic pair: din 8'hF0 then 8'h3C (valid back-to-back), out_ready=1 -> out_valid on the cycle after the second accept with a=F0, b=3C; the AND stage yields 8'h30; pair_cnt=1.
REQ-037 Backpressure: complete a pair and hold out_ready=0 for 5 cycles with din_valid=1, din=8'hFF -> din_ready=0, a and b unchanged, state=2; out_ready=1 -> LOAD_A on the next edge.
REQ-038 Abort: accept 8'hAA, then clr=1 together with din_valid=1, din=8'h55 -> state=0, b not loaded; the next word 8'h11 loads a.
REQ-039 Async reset mid-pair: assert rst between edges while in LOAD_B -> a=b=0, state=0 and out_valid=0 immediately, before the next edge.
REQ-040 Wrap: consume 256 pairs -> pair_cnt returns to 0; the 257th pair gives pair_cnt=1.
REQ-041 Gapped input: din_valid toggling 1,0,0,1 -> two words accepted exactly on the valid cycles, and out_valid rises one cycle after the second accept.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Typed view of the operand loader encodings, built on the shared include file.
package operand_loader_pkg;

    `include "operand_defs.vh"

    typedef enum logic [1:0] {
        S_LOAD_A = LOAD_A,
        S_LOAD_B = LOAD_B,
        S_HOLD   = HOLD
    } state_t;

endpackage

// File: rtl/operand_defs.vh
// Shared state encodings and default operand width for the operand loader.
`ifndef OPERAND_DEFS_VH
`define OPERAND_DEFS_VH

localparam logic [1:0] LOAD_A = 2'd0;
localparam logic [1:0] LOAD_B = 2'd1;
localparam logic [1:0] HOLD   = 2'd2;

localparam int OPERAND_WIDTH = 8;

`endif

// File: rtl/operand_reg.sv
// WIDTH-bit operand register with asynchronous active-high reset and load enable.
module operand_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/operand_loader.sv
// Collects two operand words from a valid/ready source and presents them as a
// registered pair to the downstream AND stage, counting consumed pairs.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       state,
    output logic [7:0]       pair_cnt
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_load_a;
    logic       w_load_b;
    logic       w_cnt_inc;
    logic [7:0] r_pair_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // clr overrides every handshake, so no load or count happens on an abort edge.
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_cnt_inc    = 1'b0;
        if (clr) begin
            w_state_next = S_LOAD_A;
        end else begin
            case (r_state)
                S_LOAD_A: begin
                    if (din_valid) begin
                        w_load_a     = 1'b1;
                        w_state_next = S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (din_valid) begin
                        w_load_b     = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        w_cnt_inc    = 1'b1;
                        w_state_next = S_LOAD_A;
                    end
                end
                default: w_state_next = S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair_cnt <= 8'd0;
        end else if (w_cnt_inc) begin
            r_pair_cnt <= r_pair_cnt + 8'd1;
        end
    end

    operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_a),
        .i_d    (din),
        .o_q    (a)
    );

    operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_b),
        .i_d    (din),
        .o_q    (b)
    );

    assign din_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign out_valid = (r_state == S_HOLD);
    assign state     = r_state;
    assign pair_cnt  = r_pair_cnt;

endmodule
